mem_stage: RTL and testbench

Memory-access stage of the five-stage RISC-V pipeline. It sits between the EX/MEM register and the register file write port. It executes LB/LH/LW/LBU/LHU/SB/SH/SW over a byte-wide memory bus, one byte per cycle. It raises a combinational stall while a multi-byte access is in flight, and drives registered writeback signals straight into the register file's `waddr`/`we`/`wdata`.

---
 rtl/mem_stage_if.sv | 35 +++
 rtl/mem_stage.sv | 163 ++++++++++++++++
 tb/tb_mem_stage.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// EX/MEM slot, byte-wide memory bus and writeback port of the memory-access stage.
// The stage connects through the slave modport; the upstream side connects through master.
interface mem_stage_if #(parameter int MEM_ADDR_W = 32);
    logic                  valid;
    logic                  mem_read;
    logic                  mem_write;
    logic [2:0]            funct3;
    logic [MEM_ADDR_W-1:0] addr;
    logic [31:0]           sdata;
    logic [4:0]            ex_wd;
    logic                  ex_wreg;
    logic [31:0]           ex_wdata;

    logic [MEM_ADDR_W-1:0] mem_a;
    logic                  mem_wr;
    logic [7:0]            mem_dout;
    logic [7:0]            mem_din;

    logic                  stall_req;
    logic [4:0]            wd;
    logic                  wreg;
    logic [31:0]           wdata;

    modport slave (
        input  valid, mem_read, mem_write, funct3, addr, sdata,
        input  ex_wd, ex_wreg, ex_wdata, mem_din,
        output mem_a, mem_wr, mem_dout, stall_req, wd, wreg, wdata
    );

    modport master (
        output valid, mem_read, mem_write, funct3, addr, sdata,
        output ex_wd, ex_wreg, ex_wdata, mem_din,
        input  mem_a, mem_wr, mem_dout, stall_req, wd, wreg, wdata
    );
endinterface

// File: rtl/mem_stage.sv
// RISC-V memory-access stage: byte-serial loads/stores over an 8-bit bus,
// combinational stall while a multi-byte access is in flight, registered writeback.
module mem_stage #(
    parameter int MEM_ADDR_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.slave  bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] STORE = 2'd2;

    logic [1:0]            state, state_next;
    logic [2:0]            cnt, cnt_next;
    logic [23:0]           load_buf;
    logic [2:0]            nbytes;
    logic                  is_load, is_store;
    logic [MEM_ADDR_W-1:0] mem_a_c;
    logic                  mem_wr_c;
    logic [7:0]            mem_dout_c;
    logic                  stall_c;
    logic                  load_done;
    logic                  capture;
    logic                  sign;
    logic [31:0]           load_val;

    function automatic logic [7:0] store_byte(input logic [31:0] d, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        return b;
    endfunction

    always_comb begin
        case (bus.funct3[1:0])
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
        is_load  = bus.valid & bus.mem_read;
        is_store = bus.valid & bus.mem_write & ~bus.mem_read;
    end

    // cnt counts bytes already presented; a load needs one extra cycle for the last read byte
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        mem_a_c    = '0;
        mem_wr_c   = 1'b0;
        mem_dout_c = 8'h00;
        stall_c    = 1'b0;
        load_done  = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (is_load) begin
                    mem_a_c    = bus.addr;
                    stall_c    = 1'b1;
                    state_next = LOAD;
                    cnt_next   = 3'd1;
                end else if (is_store) begin
                    mem_a_c    = bus.addr;
                    mem_wr_c   = 1'b1;
                    mem_dout_c = store_byte(bus.sdata, 2'd0);
                    if (nbytes != 3'd1) begin
                        stall_c    = 1'b1;
                        state_next = STORE;
                        cnt_next   = 3'd1;
                    end
                end
            end
            LOAD: begin
                if (cnt == nbytes) begin
                    load_done  = 1'b1;
                    state_next = IDLE;
                    cnt_next   = 3'd0;
                end else begin
                    mem_a_c  = bus.addr + MEM_ADDR_W'(cnt);
                    stall_c  = 1'b1;
                    capture  = 1'b1;
                    cnt_next = cnt + 3'd1;
                end
            end
            STORE: begin
                mem_a_c    = bus.addr + MEM_ADDR_W'(cnt);
                mem_wr_c   = 1'b1;
                mem_dout_c = store_byte(bus.sdata, cnt[1:0]);
                if (cnt == nbytes - 3'd1) begin
                    state_next = IDLE;
                    cnt_next   = 3'd0;
                end else begin
                    stall_c  = 1'b1;
                    cnt_next = cnt + 3'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 3'd0;
            end
        endcase
    end

    // The last byte is taken straight from the bus, earlier ones from the buffer
    always_comb begin
        sign = ~bus.funct3[2] & bus.mem_din[7];
        case (nbytes)
            3'd1:    load_val = {{24{sign}}, bus.mem_din};
            3'd2:    load_val = {{16{sign}}, bus.mem_din, load_buf[7:0]};
            default: load_val = {bus.mem_din, load_buf};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            load_buf <= 24'h0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (capture) begin
                case (cnt[1:0])
                    2'd1:    load_buf[7:0]   <= bus.mem_din;
                    2'd2:    load_buf[15:8]  <= bus.mem_din;
                    default: load_buf[23:16] <= bus.mem_din;
                endcase
            end
        end
    end

    // Stall edges insert a bubble; stores never write a register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.wd    <= 5'd0;
            bus.wreg  <= 1'b0;
            bus.wdata <= 32'h0;
        end else if (stall_c) begin
            bus.wreg <= 1'b0;
        end else if (load_done) begin
            bus.wd    <= bus.ex_wd;
            bus.wreg  <= bus.ex_wreg;
            bus.wdata <= load_val;
        end else if (state == STORE || (state == IDLE && is_store)) begin
            bus.wreg <= 1'b0;
        end else if (state == IDLE) begin
            bus.wd    <= bus.ex_wd;
            bus.wreg  <= bus.ex_wreg & bus.valid;
            bus.wdata <= bus.ex_wdata;
        end
    end

    assign bus.mem_a     = rst ? '0    : mem_a_c;
    assign bus.mem_wr    = rst ? 1'b0  : mem_wr_c;
    assign bus.mem_dout  = rst ? 8'h00 : mem_dout_c;
    assign bus.stall_req = rst ? 1'b0  : stall_c;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, reset-mid-load sequence
// and random ops checked against a byte-array reference memory.
module tb_mem_stage;

    localparam int KIND_ALU = 0, KIND_LOAD = 1, KIND_STORE = 2, KIND_BUBBLE = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] dut_mem [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    mem_stage_if #(.MEM_ADDR_W(32)) bus ();

    mem_stage #(.MEM_ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dutByte(input logic [31:0] a);
        return dut_mem.exists(a) ? dut_mem[a] : 8'h00;
    endfunction

    function automatic logic [7:0] refByte(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    // Byte-wide synchronous memory: read data appears the cycle after the address
    always @(posedge clk) begin
        if (bus.mem_wr) dut_mem[bus.mem_a] = bus.mem_dout;
        bus.mem_din <= dutByte(bus.mem_a);
    end

    function automatic int sizeOf(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] refLoad(input logic [31:0] a, input logic [2:0] f3);
        int n;
        logic [31:0] v;
        n = sizeOf(f3);
        v = 32'h0;
        for (int k = 0; k < n; k++) v = v | (32'(refByte(a + 32'(k))) << (8 * k));
        if (!f3[2] && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [7:0] d);
        dut_mem[a] = d;
        ref_mem[a] = d;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] sd, input logic [4:0] wdv,
                                 input logic wrg, input logic [31:0] wdat);
        bus.valid     = v;
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.funct3    = f3;
        bus.addr      = a;
        bus.sdata     = sd;
        bus.ex_wd     = wdv;
        bus.ex_wreg   = wrg;
        bus.ex_wdata  = wdat;
    endtask

    // Presents one op from the current cycle on and follows it to its writeback edge
    task automatic runOp(input string name, input int kind, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [4:0] wdv, input logic wrg,
                         input logic [31:0] wdat, input logic [31:0] exp_val);
        int n, stalls, cyc, exp_stalls;
        n = sizeOf(f3);
        applyStimulus(kind != KIND_BUBBLE, kind == KIND_LOAD, kind == KIND_STORE, f3, a, sd, wdv, wrg, wdat);
        stalls = 0;
        cyc    = 0;
        forever begin
            @(negedge clk);
            if (kind == KIND_LOAD && cyc < n) checkOutput({name, " rd_addr"}, bus.mem_a, a + 32'(cyc));
            if (kind == KIND_STORE) begin
                checkOutput({name, " st_wr"}, 32'(bus.mem_wr), 32'd1);
                checkOutput({name, " st_addr"}, bus.mem_a, a + 32'(cyc));
                checkOutput({name, " st_byte"}, 32'(bus.mem_dout), (sd >> (8 * cyc)) & 32'hFF);
            end else begin
                checkOutput({name, " no_wr"}, 32'(bus.mem_wr), 32'd0);
            end
            if (kind == KIND_ALU || kind == KIND_BUBBLE) checkOutput({name, " idle_addr"}, bus.mem_a, 32'h0);
            if (cyc > 0) checkOutput({name, " bubble_wreg"}, 32'(bus.wreg), 32'd0);
            if (!bus.stall_req) break;
            stalls++;
            cyc++;
            if (cyc > 8) begin
                checkOutput({name, " stall_timeout"}, 32'(cyc), 32'd8);
                break;
            end
        end
        exp_stalls = (kind == KIND_LOAD) ? n : (kind == KIND_STORE) ? n - 1 : 0;
        checkOutput({name, " stall_cycles"}, 32'(stalls), 32'(exp_stalls));
        @(posedge clk);
        #1;
        checkOutput({name, " wreg"}, 32'(bus.wreg),
                    (kind == KIND_ALU || kind == KIND_LOAD) ? 32'(wrg) : 32'd0);
        if (kind == KIND_ALU || kind == KIND_LOAD) begin
            checkOutput({name, " wd"}, 32'(bus.wd), 32'(wdv));
            checkOutput({name, " wdata"}, bus.wdata, (kind == KIND_LOAD) ? exp_val : wdat);
        end
        if (kind == KIND_STORE)
            for (int k = 0; k < n; k++) ref_mem[a + 32'(k)] = 8'((sd >> (8 * k)) & 32'hFF);
    endtask

    typedef struct {
        string       name;
        int          kind;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] exp_val;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int kind;
        logic [2:0] f3;
        logic [31:0] a;

        vecs[0] = '{"alu",         KIND_ALU,    3'b010, 32'h0,        32'h0,        5'd5,  1'b1, 32'h1234_5678, 32'h0};
        vecs[1] = '{"lw",          KIND_LOAD,   3'b010, 32'h100,      32'h0,        5'd7,  1'b1, 32'h0,         32'hF234_5678};
        vecs[2] = '{"lb",          KIND_LOAD,   3'b000, 32'h180,      32'h0,        5'd8,  1'b1, 32'h0,         32'hFFFF_FF80};
        vecs[3] = '{"lbu",         KIND_LOAD,   3'b100, 32'h180,      32'h0,        5'd9,  1'b1, 32'h0,         32'h0000_0080};
        vecs[4] = '{"sw",          KIND_STORE,  3'b010, 32'h200,      32'hAABB_CCDD, 5'd3, 1'b1, 32'h0,         32'h0};
        vecs[5] = '{"lw_after_sw", KIND_LOAD,   3'b010, 32'h200,      32'h0,        5'd10, 1'b1, 32'h0,         32'hAABB_CCDD};
        vecs[6] = '{"lh_wrap",     KIND_LOAD,   3'b001, 32'hFFFF_FFFF, 32'h0,       5'd11, 1'b1, 32'h0,         32'hFFFF_9234};
        vecs[7] = '{"sb",          KIND_STORE,  3'b000, 32'h204,      32'h1122_3355, 5'd4, 1'b1, 32'h0,         32'h0};
        vecs[8] = '{"lw_after_sb", KIND_LOAD,   3'b010, 32'h204,      32'h0,        5'd12, 1'b1, 32'h0,         32'h0000_0055};
        vecs[9] = '{"bubble",      KIND_BUBBLE, 3'b010, 32'h0,        32'h0,        5'd13, 1'b1, 32'hDEAD_BEEF, 32'h0};

        preload(32'h100, 8'h78);
        preload(32'h101, 8'h56);
        preload(32'h102, 8'h34);
        preload(32'h103, 8'hF2);
        preload(32'h180, 8'h80);
        preload(32'hFFFF_FFFF, 8'h34);
        preload(32'h0000_0000, 8'h92);

        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        bus.mem_din = 8'h00;
        #1;
        checkOutput("rst wd", 32'(bus.wd), 32'd0);
        checkOutput("rst wreg", 32'(bus.wreg), 32'd0);
        checkOutput("rst wdata", bus.wdata, 32'h0);
        checkOutput("rst stall", 32'(bus.stall_req), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 10; i++)
            runOp(vecs[i].name, vecs[i].kind, vecs[i].f3, vecs[i].addr, vecs[i].sdata,
                  vecs[i].wd, vecs[i].wreg, vecs[i].wdata, vecs[i].exp_val);

        // Reset while a word load is in its cnt = 2 cycle abandons it
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd14, 1'b1, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #2;
        checkOutput("mid_load stall", 32'(bus.stall_req), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_async stall", 32'(bus.stall_req), 32'd0);
        checkOutput("rst_async mem_wr", 32'(bus.mem_wr), 32'd0);
        checkOutput("rst_async mem_a", bus.mem_a, 32'h0);
        checkOutput("rst_async wreg", 32'(bus.wreg), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst stall", 32'(bus.stall_req), 32'd0);
        checkOutput("post_rst wreg", 32'(bus.wreg), 32'd0);
        checkOutput("post_rst mem_wr", 32'(bus.mem_wr), 32'd0);
        @(posedge clk);
        #1;
        runOp("alu_after_rst", KIND_ALU, 3'b000, 32'h0, 32'h0, 5'd21, 1'b1, 32'hCAFE_F00D, 32'h0);

        for (int i = 0; i < 60; i++) begin
            kind = int'($urandom_range(0, 3));
            f3   = 3'($urandom_range(0, 7));
            a    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFD : 32'h300 + 32'($urandom_range(0, 15));
            runOp("rand", kind, f3, a, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  $urandom, refLoad(a, f3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
